// File: rtl/gate3_pkg.sv
// gate3 shared types: sweep FSM states, last sweep vector and the
// popcount helper used for the majority expectation.
package gate3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        CHECK = 2'd2
    } state_e;

    localparam logic [2:0] SWEEP_LAST = 3'd7;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/gate3_unit_core.sv
// gate3_core: combinational per-lane AND3 / OR3 (and MAJ3 when
// GATE3_MAJ_EN is defined). Ports: a_i/b_i/c_i operands; and_o/or_o/maj_o.
module gate3_core #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
`ifdef GATE3_MAJ_EN
    output logic [WIDTH-1:0] maj_o,
`endif
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o
);

    assign and_o = a_i & b_i & c_i;
    assign or_o  = a_i | b_i | c_i;
`ifdef GATE3_MAJ_EN
    assign maj_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
`endif

endmodule

// File: rtl/gate3_unit.sv
// gate3_unit: registered lane-parallel AND3/OR3 with a built-in 000..111
// self-test sweep. Ports: clk, rst (async high), in_valid, i1/i2/i3,
// sweep_start -> out_valid, and_o, or_o, sweep_busy, sweep_done,
// sweep_err. Macro GATE3_MAJ_EN adds the registered majority output maj_o.
module gate3_unit
    import gate3_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             sweep_start,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
`ifdef GATE3_MAJ_EN
    output logic [WIDTH-1:0] maj_o,
`endif
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             sweep_err
);

    state_e           state_q;
    logic [2:0]       p_q;
    logic             chk_q;
    logic [2:0]       chk_p_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             ov_q;
    logic [WIDTH-1:0] and_q;
    logic [WIDTH-1:0] or_q;

    logic             sweeping;
    logic             acc_v;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] op3;
    logic [WIDTH-1:0] and_d;
    logic [WIDTH-1:0] or_d;
    logic [WIDTH-1:0] exp_and;
    logic [WIDTH-1:0] exp_or;
    logic             mism;

    assign sweeping = (state_q == SWEEP);

    // While busy the sweep owns the datapath; in IDLE a start pulse
    // takes priority over an external operand, which is dropped.
    assign acc_v = sweeping ||
                   (state_q == IDLE && in_valid && !sweep_start);

    assign op1 = sweeping ? {WIDTH{p_q[0]}} : i1;
    assign op2 = sweeping ? {WIDTH{p_q[1]}} : i2;
    assign op3 = sweeping ? {WIDTH{p_q[2]}} : i3;

`ifdef GATE3_MAJ_EN
    logic [WIDTH-1:0] maj_d;
    logic [WIDTH-1:0] maj_q;
    logic [WIDTH-1:0] exp_maj;
`endif

    gate3_core #(.WIDTH(WIDTH)) u_core (
        .a_i   (op1),
        .b_i   (op2),
        .c_i   (op3),
`ifdef GATE3_MAJ_EN
        .maj_o (maj_d),
`endif
        .and_o (and_d),
        .or_o  (or_d)
    );

    // Expected result of the vector issued one cycle earlier.
    assign exp_and = (chk_p_q == SWEEP_LAST) ? {WIDTH{1'b1}} : '0;
    assign exp_or  = (chk_p_q == 3'd0) ? '0 : {WIDTH{1'b1}};

`ifdef GATE3_MAJ_EN
    assign exp_maj = (popcount3(chk_p_q) >= 2'd2) ? {WIDTH{1'b1}} : '0;
    assign mism = chk_q && ((and_q != exp_and) ||
                            (or_q != exp_or) ||
                            (maj_q != exp_maj));
`else
    assign mism = chk_q && ((and_q != exp_and) || (or_q != exp_or));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_q  <= 1'b0;
            and_q <= '0;
            or_q  <= '0;
        end else begin
            ov_q <= acc_v;
            if (acc_v) begin
                and_q <= and_d;
                or_q  <= or_d;
            end
        end
    end

`ifdef GATE3_MAJ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maj_q <= '0;
        end else if (acc_v) begin
            maj_q <= maj_d;
        end
    end
    assign maj_o = maj_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= 3'd0;
            chk_q   <= 1'b0;
            chk_p_q <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            chk_q  <= 1'b0;
            if (mism) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (sweep_start) begin
                        state_q <= SWEEP;
                        p_q     <= 3'd0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SWEEP: begin
                    chk_q   <= 1'b1;
                    chk_p_q <= p_q;
                    p_q     <= p_q + 3'd1;
                    if (p_q == SWEEP_LAST) begin
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = ov_q;
    assign and_o      = and_q;
    assign or_o       = or_q;
    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign sweep_err  = err_q;

endmodule

// File: tb/tb_gate3_unit.sv
// Directed bench for gate3_unit: a WIDTH=1 instance for the exhaustive
// truth table and a WIDTH=4 instance for lanes, hold, reset and sweep.
module tb_gate3_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v1 = 0, s1 = 0;
    logic [0:0] a1 = 0, b1 = 0, c1 = 0;
    logic       ov1, bz1, dn1, er1;
    logic [0:0] and1, or1;

    logic       v4 = 0, s4 = 0;
    logic [3:0] a4 = 0, b4 = 0, c4 = 0;
    logic       ov4, bz4, dn4, er4;
    logic [3:0] and4, or4;
`ifdef GATE3_MAJ_EN
    logic [0:0] maj1;
    logic [3:0] maj4;
`endif

    int nvec = 0;
    int nerr = 0;

    gate3_unit #(.WIDTH(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(v1),
        .i1(a1), .i2(b1), .i3(c1), .sweep_start(s1),
        .out_valid(ov1), .and_o(and1), .or_o(or1),
`ifdef GATE3_MAJ_EN
        .maj_o(maj1),
`endif
        .sweep_busy(bz1), .sweep_done(dn1), .sweep_err(er1)
    );

    gate3_unit #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(v4),
        .i1(a4), .i2(b4), .i3(c4), .sweep_start(s4),
        .out_valid(ov4), .and_o(and4), .or_o(or4),
`ifdef GATE3_MAJ_EN
        .maj_o(maj4),
`endif
        .sweep_busy(bz4), .sweep_done(dn4), .sweep_err(er4)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // One full sweep on u4; optional second start pulse while busy.
    task automatic sweep(input bit dbl);
        int nb = 0;
        int nv = 0;
        int nd = 0;
        int dat = -1;
        int p;
        s4 = 1; v4 = 1;
        a4 = 4'h5; b4 = 4'h3; c4 = 4'h6;
        step;
        s4 = 0;
        a4 = 4'h0; b4 = 4'h0; c4 = 4'h0;
        chk("sweep_drop_ov", ov4, 0);
        for (int i = 0; i < 12; i++) begin
            if (bz4) nb++;
            if (ov4) nv++;
            if (dn4) begin
                nd++;
                dat = i;
            end
            if (i >= 1 && i <= 8) begin
                p = i - 1;
                chk("sweep_and", and4, (p == 7) ? 4'hF : 4'h0);
                chk("sweep_or", or4, (p == 0) ? 4'h0 : 4'hF);
`ifdef GATE3_MAJ_EN
                chk("sweep_maj", maj4,
                    ((p[0] + p[1] + p[2]) >= 2) ? 4'hF : 4'h0);
`endif
            end
            v4 = (i < 7);
            s4 = (dbl && i == 2);
            step;
        end
        v4 = 0; s4 = 0;
        chk("sweep_busy_cycles", nb, 9);
        chk("sweep_ov_pulses", nv, 8);
        chk("sweep_done_pulses", nd, 1);
        chk("sweep_done_at", dat, 9);
        chk("sweep_err", er4, 0);
    endtask

    initial begin
        int nd;
        step;
        step;
        rst = 0;
        chk("rst_ov1", ov1, 0);
        chk("rst_and4", and4, 0);
        chk("rst_or4", or4, 0);
        chk("rst_busy4", bz4, 0);
        chk("rst_done4", dn4, 0);
        chk("rst_err4", er4, 0);
        step;
        chk("idle_ov1", ov1, 0);
        chk("idle_ov4", ov4, 0);

        for (int v = 0; v < 8; v++) begin
            logic [2:0] t;
            t = v[2:0];
            {c1, b1, a1} = t;
            v1 = 1;
            step;
            chk("w1_ov", ov1, 1);
            chk("w1_and", and1, (v == 7) ? 1 : 0);
            chk("w1_or", or1, (v == 0) ? 0 : 1);
        end
        v1 = 0;
        {c1, b1, a1} = 3'b000;
        step;
        chk("w1_drop_ov", ov1, 0);
        chk("w1_hold_and", and1, 1);

        a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b1110; v4 = 1;
        step;
        chk("lane_ov", ov4, 1);
        chk("lane_and", and4, 4'b1000);
        chk("lane_or", or4, 4'b1110);
`ifdef GATE3_MAJ_EN
        chk("lane_maj", maj4, 4'b1110);
`endif
        v4 = 0;
        for (int k = 0; k < 3; k++) begin
            a4 = 4'hF; b4 = 4'hF; c4 = 4'h0;
            step;
            chk("hold_ov", ov4, 0);
            chk("hold_and", and4, 4'b1000);
            chk("hold_or", or4, 4'b1110);
        end

        a4 = 4'hF; b4 = 4'hF; c4 = 4'hF; v4 = 1;
        step;
        chk("pre_rst_and", and4, 4'hF);
        v4 = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("async_rst_and", and4, 0);
        chk("async_rst_or", or4, 0);
        chk("async_rst_ov", ov4, 0);
        step;
        rst = 0;
        step;
        chk("post_rst_ov", ov4, 0);

        sweep(1'b1);

        s4 = 1;
        step;
        s4 = 0;
        repeat (4) step;
        chk("abort_busy_pre", bz4, 1);
        #2 rst = 1;
        #1;
        chk("abort_busy", bz4, 0);
        chk("abort_ov", ov4, 0);
        step;
        rst = 0;
        nd = 0;
        for (int i = 0; i < 12; i++) begin
            if (dn4 || bz4) nd++;
            step;
        end
        chk("abort_no_done", nd, 0);

        sweep(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
